// File: rtl/branch_resolver_pkg.sv
// Shared predictor types: index/counter/word typedefs, the FIFO entry
// layout and the 2-bit saturating counter update used by predictor and resolver.
package branch_resolver_pkg;

   localparam int P_INDEX_WIDTH = 5;

   typedef logic [15:0]              lc3b_word;
   typedef logic [P_INDEX_WIDTH-1:0] lc3b_p_index;
   typedef logic [1:0]               lc3b_p_count;

   typedef struct packed {
      lc3b_p_index index;
      lc3b_p_count count;
      lc3b_word    target;
   } lc3b_pred_entry;

   // Saturating 2-bit counter: step toward taken (11) or not-taken (00).
   function automatic lc3b_p_count sat_update(input lc3b_p_count count, input logic taken);
      lc3b_p_count result;
      result = count;
      if (taken) begin
         if (count != 2'b11) result = count + 2'b01;
      end else begin
         if (count != 2'b00) result = count - 2'b01;
      end
      return result;
   endfunction

endpackage

// File: rtl/branch_resolver_fifo.sv
// In-order prediction FIFO. Combinational head read; flush collapses the
// queue onto the slot just past the popped head so wrong-path entries vanish.
module pred_fifo
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  lc3b_pred_entry               push_data,
   input  logic                         pop,
   input  logic                         flush,
   output lc3b_pred_entry               head_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   lc3b_pred_entry     mem_reg [DEPTH];
   logic [PTR_W-1:0]   head_reg, head_next;
   logic [PTR_W-1:0]   tail_reg, tail_next;
   logic [OCC_W-1:0]   occ_reg, occ_next;
   logic [DEPTH-1:0]   slot_we;
   logic               pop_fire, flush_fire, push_fire;

   assign full       = (occ_reg == OCC_W'(DEPTH));
   assign pop_fire   = pop && (occ_reg != '0);
   assign flush_fire = flush && pop_fire;
   // A full FIFO drops the push even when a pop frees a slot this cycle;
   // a flushing pop discards the same-cycle (wrong-path) push.
   assign push_fire  = push && !full && !flush_fire;

   assign head_data  = mem_reg[head_reg];
   assign occupancy  = occ_reg;

   // One write strobe per storage slot, selected by the tail pointer.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
         assign slot_we[gi] = push_fire && (tail_reg == PTR_W'(gi));
      end
   endgenerate

   // Entry storage; contents need no reset because occupancy gates validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_we[i]) mem_reg[i] <= push_data;
      end
   end

   // Next-state for pointers and the fill counter.
   always_comb begin
      head_next = head_reg;
      tail_next = tail_reg;
      occ_next  = occ_reg;
      if (pop_fire) head_next = head_reg + PTR_W'(1);
      if (flush_fire) begin
         tail_next = head_reg + PTR_W'(1);
         occ_next  = '0;
      end else begin
         if (push_fire) tail_next = tail_reg + PTR_W'(1);
         if (push_fire && !pop_fire) occ_next = occ_reg + OCC_W'(1);
         else if (!push_fire && pop_fire) occ_next = occ_reg - OCC_W'(1);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg <= '0;
         tail_reg <= '0;
         occ_reg  <= '0;
      end else begin
         head_reg <= head_next;
         tail_reg <= tail_next;
         occ_reg  <= occ_next;
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted branches in order: pops the oldest prediction when
// execute reports an outcome, writes back the saturated counter and raises a
// one-cycle mispredict/redirect when the predicted next PC was wrong.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int INDEX_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pred_valid,
   input  logic [INDEX_WIDTH-1:0]       pred_index,
   input  logic [1:0]                   pred_count,
   input  logic [15:0]                  pred_target,
   output logic                         pred_ready,
   input  logic                         res_valid,
   input  logic                         res_taken,
   input  logic [15:0]                  res_next_pc,
   output logic                         upd_enable,
   output logic [INDEX_WIDTH-1:0]       upd_index,
   output logic [1:0]                   upd_count,
   output logic                         mispredict,
   output logic [15:0]                  redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         res_error
);

   lc3b_pred_entry push_entry;
   lc3b_pred_entry head_entry;
   logic           fifo_full;
   logic           pop_fire;
   logic           target_miss;

   logic           upd_enable_reg;
   lc3b_p_index    upd_index_reg;
   lc3b_p_count    upd_count_reg;
   logic           mispredict_reg;
   lc3b_word       redirect_pc_reg;
   logic           res_error_reg;

   assign push_entry = '{index:  lc3b_p_index'(pred_index),
                         count:  pred_count,
                         target: pred_target};

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pred_valid),
      .push_data (push_entry),
      .pop       (res_valid),
      .flush     (target_miss),
      .head_data (head_entry),
      .occupancy (occupancy),
      .full      (fifo_full)
   );

   assign pred_ready  = !fifo_full;
   assign pop_fire    = res_valid && (occupancy != '0);
   // A wrong target covers both direction and target errors.
   assign target_miss = res_valid && (head_entry.target != res_next_pc);

   // Registered write-back, redirect and sticky empty-resolve error.
   always_ff @(posedge clk) begin
      if (rst) begin
         upd_enable_reg  <= 1'b0;
         upd_index_reg   <= '0;
         upd_count_reg   <= '0;
         mispredict_reg  <= 1'b0;
         redirect_pc_reg <= '0;
         res_error_reg   <= 1'b0;
      end else begin
         upd_enable_reg <= pop_fire;
         mispredict_reg <= pop_fire && target_miss;
         if (pop_fire) begin
            upd_index_reg   <= head_entry.index;
            upd_count_reg   <= sat_update(head_entry.count, res_taken);
            redirect_pc_reg <= res_next_pc;
         end
         if (res_valid && (occupancy == '0)) res_error_reg <= 1'b1;
      end
   end

   assign upd_enable  = upd_enable_reg;
   assign upd_index   = INDEX_WIDTH'(upd_index_reg);
   assign upd_count   = upd_count_reg;
   assign mispredict  = mispredict_reg;
   assign redirect_pc = redirect_pc_reg;
   assign res_error   = res_error_reg;

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Resolution side of the bimodal predictor. Fetch reads a 2-bit counter and a predicted next PC; this block records each prediction in an in-order FIFO.
- At execute it pops the oldest entry and compares it with the actual outcome.
- It drives the predictor's counter write-back (saturating update) and a mispredict/redirect to fetch. On a mispredict it flushes younger, wrong-path entries.

Parameters:
- DEPTH, 4: max in-flight predicted branches; power of 2, at least 2.
- INDEX_WIDTH, 5: predictor index width; must match lc3b_p_index (32-entry table).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pred_valid  in  1  fetch pushes a prediction this cycle
- pred_index  in  INDEX_WIDTH  predictor index used at fetch
- pred_count  in  2  counter value read at fetch
- pred_target  in  16  predicted next PC (lc3b_word)
- pred_ready  out  1  FIFO not full
- res_valid  in  1  execute resolves the oldest branch this cycle
- res_taken  in  1  actual direction
- res_next_pc  in  16  actual next PC
- upd_enable  out  1  counter write strobe to predictor
- upd_index  out  INDEX_WIDTH  index to write
- upd_count  out  2  new counter value
- mispredict  out  1  one-cycle pulse: flush front end
- redirect_pc  out  16  correct PC, valid while mispredict is high
- occupancy  out  $clog2(DEPTH+1)  entries held
- res_error  out  1  sticky: res_valid arrived while the FIFO was empty

Behaviour:
- Reset: FIFO empty, head and tail 0, occupancy 0, pred_ready 1. upd_enable, upd_index, upd_count, mispredict, redirect_pc and res_error are all 0. Reset overrides all same-cycle events.
- Push: accepted when pred_valid && pred_ready. Stores {index, count, target} at tail; tail wraps modulo DEPTH. pred_ready = (occupancy != DEPTH), combinational from registered state only. A push while full is dropped, even if a pop happens in the same cycle.
- Pop: res_valid with occupancy > 0 reads the head entry (combinational read) and advances head.
- Update and mispredict outputs are registered, one cycle after the res_valid edge. Each is a single-cycle pulse.
- Counter update, on every pop: upd_enable=1, upd_index=entry.index.
  - Taken: 00→01, 01→10, 10→11, 11→11.
  - Not taken: 11→10, 10→01, 01→00, 00→00.
  - Always uses the stored count. A stale count from two in-flight branches with the same index is accepted.
- Mispredict is decided at pop: mispredict = (entry.target != res_next_pc). Covers both direction and target error. redirect_pc = res_next_pc.
- Flush, on a mispredicting pop:
  - tail is set to the new head; occupancy becomes 0.
  - A push in the same cycle is discarded (wrong path).
  - A push in the next cycle, while mispredict is high, is accepted normally; the fetch owner must already be redirected.
- Simultaneous push and correct pop: occupancy unchanged; works at any fill level from 1 to DEPTH-1, and at DEPTH only the pop takes effect.
- res_valid while empty: ignored (no update, no mispredict); res_error is set and holds until rst.
- Pointers are log2(DEPTH) bits with natural wrap. Occupancy is a separate counter that never exceeds DEPTH and never underflows.

Decomposition:
- lc3b_types gains:
  - lc3b_p_count (logic [1:0])
  - lc3b_pred_entry struct {lc3b_p_index index; lc3b_p_count count; lc3b_word target}
  - function sat_update(lc3b_p_count, logic taken) returning lc3b_p_count, shared with the predictor
- One sub-module: pred_fifo. Parameterised DEPTH, lc3b_pred_entry storage, push, pop and flush inputs, head data, occupancy and full outputs.
- The resolve/update logic stays in branch_resolver.

Test Plan:
- Reset, then push {idx 3, cnt 10, tgt x0040}, resolve taken with next_pc x0040 → next cycle: upd_enable=1, upd_index=3, upd_count=11, mispredict=0; occupancy 1→0.
- Push {idx 7, cnt 10, tgt x0040}, resolve not-taken with next_pc x0022 → upd_count=01, mispredict=1, redirect_pc=x0022 for exactly one cycle.
- Push 4 entries (occupancy 4, pred_ready=0), push a 5th → dropped. Then 4 correct resolves → entries return in order; upd_count follows 00→01 and 11→11 saturation.
- Push 3 entries, mispredict the first with a push in the same cycle → occupancy 0, the same-cycle push is absent. A push the next cycle is accepted (occupancy 1).
- res_valid while empty → no upd_enable, no mispredict; res_error=1 and stays high. rst clears it.
- Wrap-around: 10 push/pop pairs through DEPTH=4 with a simultaneous push and pop each cycle at occupancy 2 → data integrity holds and occupancy stays 2.
